// File: rtl/i2c_adc_target.sv
// i2c_adc_target: I2C target serving a 16-bit conversion value (pointer 0)
// and a 16-bit config register (pointer 1); pointers 2/3 read as zero.
// Optional build macro: I2C_TGT_FILTER_EN adds a 3-sample glitch filter
// after each pad synchronizer. Without it, the synchronizer outputs are used
// directly.
module i2c_adc_target #(
  parameter logic [6:0]  ADDR    = 7'h48,
  parameter logic [15:0] CFG_RST = 16'h8583
) (
  input  logic        i_Clk,
  input  logic        rst,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic        o_sda_oe,
  input  logic [15:0] i_conv,
  output logic [15:0] o_config,
  output logic        o_config_wr,
  output logic        o_rd_strobe,
  output logic        o_busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_ACK  = 3'd2;
  localparam logic [2:0] S_WR_BYTE   = 3'd3;
  localparam logic [2:0] S_WR_ACK    = 3'd4;
  localparam logic [2:0] S_RD_BYTE   = 3'd5;
  localparam logic [2:0] S_RD_ACK    = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  // Bit 1 carries SCL, bit 0 carries SDA through the input conditioning.
  logic [1:0] w_pad;
  logic [1:0] w_line;
  assign w_pad = {i_scl, i_sda};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic r_meta;
      logic r_sync;

      // Two-flop synchronizer; idles high like an undriven bus line.
      always_ff @(posedge i_Clk) begin
        if (rst) begin
          r_meta <= 1'b1;
          r_sync <= 1'b1;
        end else begin
          r_meta <= w_pad[gi];
          r_sync <= r_meta;
        end
      end

`ifdef I2C_TGT_FILTER_EN
      logic [1:0] r_hist;
      logic       r_hold;
      logic       w_agree;
      logic       w_filt;

      // Output follows the line only once three consecutive samples agree.
      assign w_agree = (r_sync == r_hist[0]) && (r_hist[0] == r_hist[1]);
      assign w_filt  = w_agree ? r_sync : r_hold;

      // Sample history and last agreed value.
      always_ff @(posedge i_Clk) begin
        if (rst) begin
          r_hist <= 2'b11;
          r_hold <= 1'b1;
        end else begin
          r_hist <= {r_hist[0], r_sync};
          r_hold <= w_filt;
        end
      end

      assign w_line[gi] = w_filt;
`else
      assign w_line[gi] = r_sync;
`endif
    end
  endgenerate

  logic w_scl;
  logic w_sda;
  assign w_scl = w_line[1];
  assign w_sda = w_line[0];

  logic r_scl_prev;
  logic r_sda_prev;

  // Previous conditioned levels for edge and START/STOP detection.
  always_ff @(posedge i_Clk) begin
    if (rst) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  // SDA may only move with SCL high when the master signals START or STOP.
  assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

  logic [2:0]  r_state;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_tx_shift;
  logic [1:0]  r_wr_idx;
  logic [1:0]  r_ptr;
  logic [7:0]  r_data_msb;
  logic [15:0] r_config;
  logic [15:0] r_shadow;
  logic        r_rw;
  logic        r_hilo;
  logic        r_mack;
  logic        r_sda_oe;
  logic        r_config_wr;
  logic        r_rd_strobe;
  logic        r_busy;

  logic [15:0] w_sel;
  logic [7:0]  w_tx_byte;

  // Register selected by the pointer for reads.
  always_comb begin
    case (r_ptr)
      2'd0:    w_sel = r_shadow;
      2'd1:    w_sel = r_config;
      default: w_sel = 16'h0000;
    endcase
  end

  // r_hilo set means the next byte sent is the LSB.
  assign w_tx_byte = r_hilo ? w_sel[7:0] : w_sel[15:8];

  // Protocol state machine; START/STOP take precedence over SCL edges.
  always_ff @(posedge i_Clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 4'd0;
      r_rx_shift  <= 8'h00;
      r_tx_shift  <= 8'h00;
      r_wr_idx    <= 2'd0;
      r_ptr       <= 2'd0;
      r_data_msb  <= 8'h00;
      r_config    <= CFG_RST;
      r_shadow    <= 16'h0000;
      r_rw        <= 1'b0;
      r_hilo      <= 1'b0;
      r_mack      <= 1'b1;
      r_sda_oe    <= 1'b0;
      r_config_wr <= 1'b0;
      r_rd_strobe <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_config_wr <= 1'b0;
      r_rd_strobe <= 1'b0;
      if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= 4'd0;
        r_wr_idx  <= 2'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b1;
      end else if (w_stop) begin
        if (r_state != S_IDLE) begin
          r_state  <= S_IDLE;
          r_sda_oe <= 1'b0;
          r_busy   <= 1'b0;
        end
      end else begin
        case (r_state)
          S_ADDR, S_WR_BYTE: begin
            if (w_scl_rise && (r_bit_cnt != 4'd8)) begin
              r_rx_shift <= {r_rx_shift[6:0], w_sda};
              r_bit_cnt  <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
              if (r_state == S_ADDR) begin
                r_rw <= r_rx_shift[0];
                if (r_rx_shift[7:1] == ADDR) begin
                  r_state  <= S_ADDR_ACK;
                  r_sda_oe <= 1'b1;
                  if (r_rx_shift[0]) begin
                    // Freeze the conversion so MSB and LSB are coherent.
                    r_shadow    <= i_conv;
                    r_rd_strobe <= (r_ptr == 2'd0);
                  end
                end else begin
                  r_state  <= S_WAIT_STOP;
                  r_sda_oe <= 1'b0;
                  r_busy   <= 1'b0;
                end
              end else begin
                r_state  <= S_WR_ACK;
                r_sda_oe <= 1'b1;
                case (r_wr_idx)
                  2'd0: r_ptr      <= r_rx_shift[1:0];
                  2'd1: r_data_msb <= r_rx_shift;
                  2'd2: begin
                    if (r_ptr == 2'd1) begin
                      r_config    <= {r_data_msb, r_rx_shift};
                      r_config_wr <= 1'b1;
                    end
                  end
                  default: ;
                endcase
                if (r_wr_idx != 2'd3) begin
                  r_wr_idx <= r_wr_idx + 2'd1;
                end
              end
            end
          end
          S_ADDR_ACK, S_WR_ACK: begin
            if (w_scl_fall) begin
              if ((r_state == S_ADDR_ACK) && r_rw) begin
                r_state    <= S_RD_BYTE;
                r_tx_shift <= w_sel[15:8];
                r_sda_oe   <= ~w_sel[15];
                r_bit_cnt  <= 4'd1;
                r_hilo     <= 1'b1;
              end else begin
                r_state   <= S_WR_BYTE;
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 4'd0;
              end
            end
          end
          S_RD_BYTE: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_state  <= S_RD_ACK;
                r_sda_oe <= 1'b0;
              end else begin
                r_sda_oe   <= ~r_tx_shift[6];
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                r_bit_cnt  <= r_bit_cnt + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (w_scl_rise) begin
              r_mack <= w_sda;
            end else if (w_scl_fall) begin
              if (!r_mack) begin
                r_state    <= S_RD_BYTE;
                r_tx_shift <= w_tx_byte;
                r_sda_oe   <= ~w_tx_byte[7];
                r_bit_cnt  <= 4'd1;
                r_hilo     <= ~r_hilo;
              end else begin
                r_state  <= S_WAIT_STOP;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
              end
            end
          end
          default: begin
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_sda_oe    = r_sda_oe;
  assign o_config    = r_config;
  assign o_config_wr = r_config_wr;
  assign o_rd_strobe = r_rd_strobe;
  assign o_busy      = r_busy;

endmodule
